memory_cycle: RTL

- MEM stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
- Holds the data memory: synchronous write, combinational read, addressed by ALUResultM.
- Registers the MEM/WB pipeline boundary and drives the writeback result mux (ResultW) to the register file.
- Flags misaligned accesses combinationally for hazard/trap logic.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/memory_cycle_data_memory.sv | 29 ++
 rtl/memory_cycle.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: writeback-select encodings, load/store width codes
// and the MEM/WB pipeline register layout.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_ALU2 = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic            regwrite;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc4;
  } memwb_t;

endpackage

// File: rtl/memory_cycle_data_memory.sv
// Word-organised data memory: combinational read, synchronous write with
// per-byte lane enables. Contents are not reset.
module data_memory
  import riscv_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [3:0]      be_i,
  input  logic [AW-1:0]   idx_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// RV32I MEM stage: data memory access, misalignment flag, MEM/WB registers and
// the writeback result mux. MEM_SUBWORD_EN adds byte/halfword loads and stores.
module memory_cycle
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  output logic        MisalignedM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ResultW
);

  logic              access;
  logic              mem_we;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic [XLEN-1:0]   ld_data;
  logic [ADDR_W-1:0] idx;
  memwb_t            wb_d, wb_q;

  assign access = MemWriteM | (ResultSrcM == RES_MEM);
  assign idx    = ALUResultM[ADDR_W+1:2];

`ifdef MEM_SUBWORD_EN
  logic [XLEN-1:0] shifted;

  always_comb begin
    MisalignedM = 1'b0;
    be          = 4'b1111;
    wdata       = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        be    = 4'b0001 << ALUResultM[1:0];
        wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        MisalignedM = access & ALUResultM[0];
        be          = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata       = {2{WriteDataM[15:0]}};
      end
      default: MisalignedM = access & (ALUResultM[1:0] != 2'b00);
    endcase
  end

  // Little-endian lane select; Funct3M[2] marks the unsigned variants.
  assign shifted = rdata >> {ALUResultM[1:0], 3'b000};

  always_comb begin
    ld_data = rdata;
    unique case (Funct3M[1:0])
      2'b00:   ld_data = {{24{shifted[7]  & ~Funct3M[2]}}, shifted[7:0]};
      2'b01:   ld_data = {{16{shifted[15] & ~Funct3M[2]}}, shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^Funct3M;
  assign MisalignedM   = access & (ALUResultM[1:0] != 2'b00);
  assign be            = 4'b1111;
  assign wdata         = WriteDataM;
  assign ld_data       = rdata;
`endif

  // Gating with rst means a reset landing before the edge cancels the store.
  assign mem_we = MemWriteM & ~MisalignedM & rst;

  data_memory #(.DEPTH(DEPTH), .AW(ADDR_W)) u_dmem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (be),
    .idx_i   (idx),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_comb begin
    wb_d.regwrite   = RegWriteM;
    wb_d.result_src = ResultSrcM;
    wb_d.alu        = ALUResultM;
    wb_d.rdata      = ld_data;
    wb_d.rd         = RdM;
    wb_d.pc4        = PCPlus4M;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= wb_d;
  end

  assign RegWriteW  = wb_q.regwrite;
  assign ResultSrcW = wb_q.result_src;
  assign ALUResultW = wb_q.alu;
  assign ReadDataW  = wb_q.rdata;
  assign RdW        = wb_q.rd;
  assign PCPlus4W   = wb_q.pc4;

  always_comb begin
    unique case (wb_q.result_src)
      RES_MEM: ResultW = wb_q.rdata;
      RES_PC4: ResultW = wb_q.pc4;
      default: ResultW = wb_q.alu;
    endcase
  end

endmodule
